// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port arbiter: sequences little-endian word fetches (IF) and byte/half/word loads/stores (MEM).
// Optional IF starvation guard enabled by defining MEMARB_STARVE_GUARD_EN.
//
// Handshake: a requester raises *_req_in and holds it level, with stable address/data,
// until its *_done_out pulse; requests are accepted only in IDLE, and a requester whose
// done pulse is high in that cycle is never re-granted in the same cycle.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_flush_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_width_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  output logic [1:0]        state_dbg_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic              prime_q, prime_d;
  logic              own_if_q, own_if_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic       grant_mem, grant_if, if_pend, mem_pend, force_if;
  logic [1:0] cnt_nxt;

`ifdef MEMARB_STARVE_GUARD_EN
  logic [1:0] starve_q, starve_d;
  assign force_if = (starve_q == 2'd3) && if_pend;
`else
  assign force_if = 1'b0;
`endif

  assign if_pend  = if_req_in && !if_flush_in && !if_done_q;
  assign mem_pend = mem_req_in && !mem_done_q;
  assign cnt_nxt  = cnt_q + 2'd1;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      prime_q     <= 1'b0;
      own_if_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
`ifdef MEMARB_STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      prime_q     <= prime_d;
      own_if_q    <= own_if_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef MEMARB_STARVE_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

  // Next state and arbitration; a flush only aborts a fetch, never a MEM read.
  always_comb begin
    state_d   = state_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_pend && !force_if) grant_mem = 1'b1;
        else if (if_pend)          grant_if  = 1'b1;
        if (grant_mem)     state_d = mem_we_in ? WRITE : READ;
        else if (grant_if) state_d = READ;
      end
      READ: begin
        if (own_if_q && if_flush_in)          state_d = IDLE;
        else if (!prime_q && cnt_q == last_q) state_d = IDLE;
      end
      WRITE: begin
        if (cnt_q == last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: in READ the address runs one byte ahead of the byte being sampled.
  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    prime_d     = prime_q;
    own_if_d    = own_if_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
`ifdef MEMARB_STARVE_GUARD_EN
    starve_d    = starve_q;
    if (grant_if) starve_d = '0;
    else if (grant_mem && if_req_in && starve_q != 2'd3) starve_d = starve_q + 2'd1;
`endif
    case (state_q)
      IDLE: begin
        if (grant_mem || grant_if) begin
          own_if_d = grant_if;
          addr_d   = grant_if ? if_addr_in : mem_addr_in;
          cnt_d    = '0;
          prime_d  = 1'b1;
          buf_d    = '0;
          wdata_d  = mem_wdata_in;
          if (grant_if || mem_width_in[1]) last_d = 2'd3;
          else                             last_d = {1'b0, mem_width_in[0]};
          if (grant_mem && mem_we_in) begin
            wr_d   = 1'b1;
            dout_d = mem_wdata_in[7:0];
          end
        end
      end
      READ: begin
        if (!(own_if_q && if_flush_in)) begin
          addr_d  = addr_q + ADDR_W'(1);
          prime_d = 1'b0;
          if (!prime_q) begin
            buf_d[{cnt_q, 3'b000} +: 8] = ram_din_in;
            cnt_d = cnt_nxt;
            if (cnt_q == last_q) begin
              if (own_if_q) begin
                if_done_d = 1'b1;
                if_data_d = buf_d;
              end else begin
                mem_done_d  = 1'b1;
                mem_rdata_d = buf_d;
              end
            end
          end
        end
      end
      WRITE: begin
        if (cnt_q == last_q) begin
          wr_d       = 1'b0;
          mem_done_d = 1'b1;
        end else begin
          cnt_d  = cnt_nxt;
          addr_d = addr_q + ADDR_W'(1);
          dout_d = wdata_q[{cnt_nxt, 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_a_out     = addr_q;
    ram_dout_out  = dout_q;
    ram_wr_out    = wr_q && rdy_in;
    if_done_out   = if_done_q;
    if_data_out   = if_data_q;
    mem_done_out  = mem_done_q;
    mem_rdata_out = mem_rdata_q;
    state_dbg_out = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, transaction-level timing model with a per-cycle compare,
// and directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk, rst_n, rdy;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_flush_in(if_flush),
    .if_done_out(if_done), .if_data_out(if_data),
    .mem_req_in(mem_req), .mem_we_in(mem_we), .mem_width_in(mem_width),
    .mem_addr_in(mem_addr), .mem_wdata_in(mem_wdata),
    .mem_done_out(mem_done), .mem_rdata_out(mem_rdata),
    .ram_din_in(ram_din), .ram_dout_out(ram_dout), .ram_a_out(ram_a),
    .ram_wr_out(ram_wr), .state_dbg_out(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model (frozen with the rest of the system when rdy is low) ----------------
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      ram_din <= rd(ram_a);
      if (ram_wr) ram[ram_a] = ram_dout;
    end
  end

  // ---------------- transaction-level model ----------------
  // State values: 0=IDLE, 1=READ, 2=WRITE.
  bit          chk_en = 0;
  bit          m_busy, m_if, m_we;
  int          m_n, m_c, m_starve;
  logic [31:0] m_base, m_wdata, m_data;
  bit          e_rst, e_if_done, e_mem_done, e_mem_load, e_a_care, e_wr;
  logic [31:0] e_a, e_if_data, e_mem_rdata;
  logic [7:0]  e_dout;
  logic [1:0]  e_state;

  task automatic m_start(input bit is_if);
    m_busy = 1; m_if = is_if; m_c = 1;
    m_we    = is_if ? 1'b0 : mem_we;
    m_base  = is_if ? if_addr : mem_addr;
    m_wdata = mem_wdata;
    m_n     = is_if ? 4 : (mem_width == 2'd0 ? 1 : (mem_width == 2'd1 ? 2 : 4));
    m_data  = 32'h0;
    for (int k = 0; k < m_n; k++) m_data = m_data | (32'(rd(m_base + 32'(k))) << (8 * k));
  endtask

  always @(posedge clk) begin
    bit ifd, memd, if_pend, mem_pend, take_if;
    if (!rst_n) begin
      m_busy = 0; m_starve = 0;
      e_rst = 1; e_if_done = 0; e_mem_done = 0; e_wr = 0; e_dout = 8'h00;
      e_a = 32'h0; e_a_care = 1; e_state = 2'd0;
      e_if_data = 32'h0; e_mem_rdata = 32'h0;
      chk_en = 1;
    end else if (rdy) begin
      e_rst = 0;
      ifd = e_if_done; memd = e_mem_done;
      e_if_done = 0; e_mem_done = 0;
      if (m_busy) begin
        if (m_if && if_flush) m_busy = 0;
        else begin
          m_c++;
          if (m_c == m_n + (m_we ? 1 : 2)) begin
            m_busy = 0;
            if (m_if) begin e_if_done = 1; e_if_data = m_data; end
            else begin
              e_mem_done = 1; e_mem_load = !m_we;
              if (!m_we) e_mem_rdata = m_data;
            end
          end
        end
      end else begin
        if_pend  = if_req && !if_flush && !ifd;
        mem_pend = mem_req && !memd;
`ifdef MEMARB_STARVE_GUARD_EN
        take_if = if_pend && (!mem_pend || m_starve == 3);
`else
        take_if = if_pend && !mem_pend;
`endif
        if (take_if) begin
          m_start(1'b1); m_starve = 0;
        end else if (mem_pend) begin
          if (if_req && m_starve < 3) m_starve++;
          m_start(1'b0);
        end
      end
      e_a_care = 0; e_wr = 0;
      if (m_busy) begin
        e_state = m_we ? 2'd2 : 2'd1;
        if (m_c >= 1 && m_c <= m_n) begin
          e_a_care = 1;
          e_a = m_base + 32'(m_c) - 32'd1;
          if (m_we) begin
            e_wr = 1;
            e_dout = 8'(m_wdata >> (8 * (m_c - 1)));
          end
        end
      end else e_state = 2'd0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", {30'h0, state_dbg}, {30'h0, e_state});
      check("if_done", {31'h0, if_done}, {31'h0, e_if_done});
      check("mem_done", {31'h0, mem_done}, {31'h0, e_mem_done});
      check("ram_wr", {31'h0, ram_wr}, {31'h0, e_wr & rdy});
      if (e_a_care) check("ram_a", ram_a, e_a);
      if (e_wr) check("ram_dout", {24'h0, ram_dout}, {24'h0, e_dout});
      if (e_if_done) check("if_data", if_data, e_if_data);
      if (e_mem_done && e_mem_load) check("mem_rdata", mem_rdata, e_mem_rdata);
      if (e_rst) begin
        check("rst_dout", {24'h0, ram_dout}, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  int          if_cyc, mem_cyc, strobes, stall_lo, stall_hi;
  logic [31:0] if_word, mem_word;
  logic [31:0] a_log [1:16];

  task automatic run(input int max);
    if_cyc = 0; mem_cyc = 0; strobes = 0;
    for (int j = 1; j <= max; j++) begin
      tick();
      rdy = (j >= stall_lo && j <= stall_hi) ? 1'b0 : 1'b1;
      #1;
      if (ram_wr) strobes++;
      if (j <= 16) a_log[j] = ram_a;
      if (if_done && if_cyc == 0) begin if_cyc = j; if_word = if_data; if_req = 1'b0; end
      if (mem_done && mem_cyc == 0) begin mem_cyc = j; mem_word = mem_rdata; mem_req = 1'b0; end
    end
  endtask

  task automatic mem_op(input bit we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    mem_we = we; mem_width = w; mem_addr = a; mem_wdata = d; mem_req = 1'b1;
  endtask

  initial begin
    rst_n = 0; rdy = 1; if_req = 0; if_flush = 0; if_addr = 0;
    mem_req = 0; mem_we = 0; mem_width = 0; mem_addr = 0; mem_wdata = 0;
    stall_lo = 100; stall_hi = 0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h1004] = 8'h78; ram[32'h1005] = 8'h56; ram[32'h1006] = 8'h34; ram[32'h1007] = 8'h12;
    ram[32'h3001] = 8'h34; ram[32'h3002] = 8'h12; ram[32'h3003] = 8'h99;
    tick(); tick();
    check("reset_ram_a", ram_a, 32'h0);
    check("reset_state", {30'h0, state_dbg}, 32'h0);
    rst_n = 1;
    tick();

    // Word fetch
    if_addr = 32'h1000; if_req = 1;
    run(10);
    check("fetch_cycle", if_cyc, 6);
    check("fetch_data", if_word, 32'h0000_0013);
    check("fetch_a1", a_log[1], 32'h1000);
    check("fetch_a4", a_log[4], 32'h1003);

    // Store word
    mem_op(1, 2'd2, 32'h2000, 32'hDEAD_BEEF);
    run(8);
    check("store_cycle", mem_cyc, 5);
    check("store_strobes", strobes, 4);
    check("store_bytes", {rd(32'h2003), rd(32'h2002), rd(32'h2001), rd(32'h2000)}, 32'hDEAD_BEEF);

    // Half, byte and width-3 loads
    mem_op(0, 2'd1, 32'h3001, 32'h0);
    run(8);
    check("half_cycle", mem_cyc, 4);
    check("half_data", mem_word, 32'h0000_1234);
    mem_op(0, 2'd0, 32'h3003, 32'h0);
    run(8);
    check("byte_cycle", mem_cyc, 3);
    check("byte_data", mem_word, 32'h0000_0099);
    mem_op(0, 2'd3, 32'h2000, 32'h0);
    run(9);
    check("w3_cycle", mem_cyc, 6);
    check("w3_data", mem_word, 32'hDEAD_BEEF);

    // Address wrap
    mem_op(1, 2'd1, 32'hFFFF_FFFF, 32'h0000_A55A);
    run(6);
    check("wrap_store_cycle", mem_cyc, 3);
    check("wrap_byte0", {24'h0, rd(32'h0)}, 32'h0000_00A5);
    mem_op(0, 2'd1, 32'hFFFF_FFFF, 32'h0);
    run(7);
    check("wrap_load", mem_word, 32'h0000_A55A);

    // Simultaneous requests: MEM first, IF granted in the MEM done cycle
    mem_op(0, 2'd2, 32'h2000, 32'h0);
    if_addr = 32'h1000; if_req = 1;
    run(16);
    check("both_mem_cycle", mem_cyc, 6);
    check("both_if_cycle", if_cyc, 12);
    check("both_if_data", if_word, 32'h0000_0013);

    // Flush of a fetch, then a fresh fetch
    if_addr = 32'h1000; if_req = 1;
    tick();
    tick(); if_flush = 1;
    tick(); if_flush = 0; if_req = 0;
    #1 check("flush_idle", {30'h0, state_dbg}, 32'h0);
    run(8);
    check("flush_no_done", if_cyc, 0);
    if_addr = 32'h1004; if_req = 1;
    run(9);
    check("refetch_cycle", if_cyc, 6);
    check("refetch_data", if_word, 32'h1234_5678);

    // Store stalled by rdy low in cycles 2-4
    stall_lo = 2; stall_hi = 4;
    mem_op(1, 2'd2, 32'h4000, 32'h1122_3344);
    run(11);
    stall_lo = 100; stall_hi = 0;
    check("stall_cycle", mem_cyc, 8);
    check("stall_strobes", strobes, 4);
    check("stall_bytes", {rd(32'h4003), rd(32'h4002), rd(32'h4001), rd(32'h4000)}, 32'h1122_3344);

    // Reset in the middle of a load
    mem_op(0, 2'd2, 32'h2000, 32'h0);
    tick(); tick(); tick();
    rst_n = 0; mem_req = 0;
    tick();
    check("midrst_ram_a", ram_a, 32'h0);
    check("midrst_done", {30'h0, if_done, mem_done}, 32'h0);
    check("midrst_rdata", mem_rdata, 32'h0);
    rst_n = 1;
    run(8);
    check("midrst_no_done", mem_cyc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
